// File: rtl/day_scroll_pkg.sv
// Shared types, character codes, glyphs and weekday name tables for the
// scrolling day display.
package day_scroll_pkg;

  typedef enum logic {IDLE = 1'b0, SCROLL = 1'b1} state_e;

  typedef logic [3:0] char_t;

  localparam char_t CH_BLANK = 4'd0;
  localparam char_t CH_A     = 4'd1;
  localparam char_t CH_D     = 4'd2;
  localparam char_t CH_E     = 4'd3;
  localparam char_t CH_F     = 4'd4;
  localparam char_t CH_H     = 4'd5;
  localparam char_t CH_I     = 4'd6;
  localparam char_t CH_M     = 4'd7;
  localparam char_t CH_N     = 4'd8;
  localparam char_t CH_O     = 4'd9;
  localparam char_t CH_R     = 4'd10;
  localparam char_t CH_S     = 4'd11;
  localparam char_t CH_T     = 4'd12;
  localparam char_t CH_U     = 4'd13;
  localparam char_t CH_W     = 4'd14;
  localparam char_t CH_Y     = 4'd15;

  localparam logic [6:0] GL_BLANK = 7'h00;
  localparam logic [6:0] GL_A     = 7'h77;
  localparam logic [6:0] GL_D     = 7'h5E;
  localparam logic [6:0] GL_E     = 7'h79;
  localparam logic [6:0] GL_F     = 7'h71;
  localparam logic [6:0] GL_H     = 7'h76;
  localparam logic [6:0] GL_I     = 7'h06;
  localparam logic [6:0] GL_M     = 7'h15;
  localparam logic [6:0] GL_N     = 7'h37;
  localparam logic [6:0] GL_O     = 7'h3F;
  localparam logic [6:0] GL_R     = 7'h50;
  localparam logic [6:0] GL_S     = 7'h6D;
  localparam logic [6:0] GL_T     = 7'h78;
  localparam logic [6:0] GL_U     = 7'h3E;
  localparam logic [6:0] GL_W     = 7'h2A;
  localparam logic [6:0] GL_Y     = 7'h6E;

  localparam int NAME_MAX = 9;
  localparam logic [4:0] LEAD_BLANKS = 5'd4;

  // Character 0 of each name sits in the low nibble.
  typedef logic [NAME_MAX*4-1:0] name_t;

  localparam name_t NAME_SUN = {CH_BLANK, CH_BLANK, CH_BLANK, CH_Y, CH_A, CH_D, CH_N, CH_U, CH_S};
  localparam name_t NAME_MON = {CH_BLANK, CH_BLANK, CH_BLANK, CH_Y, CH_A, CH_D, CH_N, CH_O, CH_M};
  localparam name_t NAME_TUE = {CH_BLANK, CH_BLANK, CH_Y, CH_A, CH_D, CH_S, CH_E, CH_U, CH_T};
  localparam name_t NAME_WED = {CH_Y, CH_A, CH_D, CH_S, CH_E, CH_N, CH_D, CH_E, CH_W};
  localparam name_t NAME_THU = {CH_BLANK, CH_Y, CH_A, CH_D, CH_S, CH_R, CH_U, CH_H, CH_T};
  localparam name_t NAME_FRI = {CH_BLANK, CH_BLANK, CH_BLANK, CH_Y, CH_A, CH_D, CH_I, CH_R, CH_F};
  localparam name_t NAME_SAT = {CH_BLANK, CH_Y, CH_A, CH_D, CH_R, CH_U, CH_T, CH_A, CH_S};

  function automatic name_t name_word(input logic [2:0] d);
    case (d)
      3'd0:    return NAME_SUN;
      3'd1:    return NAME_MON;
      3'd2:    return NAME_TUE;
      3'd3:    return NAME_WED;
      3'd4:    return NAME_THU;
      3'd5:    return NAME_FRI;
      3'd6:    return NAME_SAT;
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] name_len(input logic [2:0] d);
    case (d)
      3'd0:    return 4'd6;
      3'd1:    return 4'd6;
      3'd2:    return 4'd7;
      3'd3:    return 4'd9;
      3'd4:    return 4'd8;
      3'd5:    return 4'd6;
      3'd6:    return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // Message = four leading blanks, the name, then blanks to the end.
  function automatic char_t msg_char(input logic [2:0] d, input logic [4:0] idx);
    logic [4:0] j;
    name_t      w;
    j = idx - LEAD_BLANKS;
    w = name_word(d) >> {j, 2'b00};
    if (idx < LEAD_BLANKS || j >= {1'b0, name_len(d)}) return CH_BLANK;
    return w[3:0];
  endfunction

endpackage

// File: rtl/day_scroll_seg_glyph.sv
// Combinational character-code to 7-segment glyph lookup (gfedcba, bit0 = a).
module seg_glyph
  import day_scroll_pkg::*;
(
  input  logic [3:0] char_i,
  output logic [6:0] glyph_o
);

  always_comb begin
    glyph_o = GL_BLANK;
    case (char_i)
      CH_A:    glyph_o = GL_A;
      CH_D:    glyph_o = GL_D;
      CH_E:    glyph_o = GL_E;
      CH_F:    glyph_o = GL_F;
      CH_H:    glyph_o = GL_H;
      CH_I:    glyph_o = GL_I;
      CH_M:    glyph_o = GL_M;
      CH_N:    glyph_o = GL_N;
      CH_O:    glyph_o = GL_O;
      CH_R:    glyph_o = GL_R;
      CH_S:    glyph_o = GL_S;
      CH_T:    glyph_o = GL_T;
      CH_U:    glyph_o = GL_U;
      CH_W:    glyph_o = GL_W;
      CH_Y:    glyph_o = GL_Y;
      default: glyph_o = GL_BLANK;
    endcase
  end

endmodule

// File: rtl/day_scroll_ctrl.sv
// Scrolls a weekday name right-to-left across four 7-segment digits with a
// start/loop/done handshake and a per-step prescaler.
module day_scroll_ctrl
  import day_scroll_pkg::*;
#(
  parameter int TICK_DIV       = 25_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  day,
  input  logic        loop,
  output logic [27:0] seg,
  output logic        busy,
  output logic        done,
  output logic        dbg_state
);

  localparam int              PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [27:0]     SEG_MASK   = SEG_ACTIVE_LOW ? 28'hFFF_FFFF : 28'h000_0000;

  state_e        state_q;
  logic [3:0]    pos_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    day_q;
  logic          busy_q;
  logic          done_q;
  logic [27:0]   seg_q;
  logic [27:0]   seg_d;

  logic       start_ok;
  logic       tick;
  logic [3:0] last_pos;

  assign start_ok = start && (day != 3'd7);
  assign tick     = (presc_q == PRESC_LAST);
  assign last_pos = name_len(day_q) + 4'd4;

  for (genvar k = 0; k < 4; k++) begin : g_digit
    char_t ch;
    assign ch = msg_char(day_q, {1'b0, pos_q} + 5'(k));
    seg_glyph u_glyph (.char_i(ch), .glyph_o(seg_d[7*k +: 7]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pos_q   <= 4'd0;
      presc_q <= '0;
      day_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= SEG_MASK;
    end else begin
      done_q <= 1'b0;
      seg_q  <= ((state_q == SCROLL) ? seg_d : 28'h000_0000) ^ SEG_MASK;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= SCROLL;
            busy_q  <= 1'b1;
            day_q   <= day;
            pos_q   <= 4'd0;
            presc_q <= '0;
          end
        end
        SCROLL: begin
          // A valid start always wins, even over the final tick's done.
          if (start_ok) begin
            day_q   <= day;
            pos_q   <= 4'd0;
            presc_q <= '0;
          end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
              if (pos_q < last_pos) begin
                pos_q <= pos_q + 4'd1;
              end else begin
                done_q <= 1'b1;
                pos_q  <= 4'd0;
                if (!loop) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seg       = seg_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = (state_q == SCROLL);

endmodule

// File: tb/tb_day_scroll_ctrl.sv
// Two scrollers (TICK_DIV=4 active-high, TICK_DIV=2 active-low) driven by one
// stimulus stream and checked cycle by cycle against a string-based model.
module tb_day_scroll_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  day;
  logic        loop;
  logic [27:0] seg_a, seg_b;
  logic        busy_a, busy_b, done_a, done_b, dbg_a, dbg_b;

  logic [29:0] exp_q0[$];
  logic [29:0] exp_q1[$];
  int          n_vec;
  int          n_err;

  string names [7] = '{"SUNDAY", "MONDAY", "TUESDAY", "WEDNESDAY", "THURSDAY", "FRIDAY", "SATURDAY"};

  bit m_act [2];
  int m_day [2];
  int m_cnt [2];

  day_scroll_ctrl #(.TICK_DIV(4), .SEG_ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .day(day), .loop(loop),
    .seg(seg_a), .busy(busy_a), .done(done_a), .dbg_state(dbg_a)
  );

  day_scroll_ctrl #(.TICK_DIV(2), .SEG_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .day(day), .loop(loop),
    .seg(seg_b), .busy(busy_b), .done(done_b), .dbg_state(dbg_b)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "A": return 7'h77;  "D": return 7'h5E;  "E": return 7'h79;  "F": return 7'h71;
      "H": return 7'h76;  "I": return 7'h06;  "M": return 7'h15;  "N": return 7'h37;
      "O": return 7'h3F;  "R": return 7'h50;  "S": return 7'h6D;  "T": return 7'h78;
      "U": return 7'h3E;  "W": return 7'h2A;  "Y": return 7'h6E;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] frame_seg(input int d, input int p);
    string       nm;
    logic [27:0] f;
    nm = names[d];
    f  = '0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = p + k - 4;
      if (i >= 0 && i < nm.len()) f[7*k +: 7] = glyph(nm[i]);
    end
    return f;
  endfunction

  // Reference model: time since the accepted start decides the frame.
  task automatic model_step(input int u);
    int          td;
    int          frames;
    logic [27:0] mask;
    logic [27:0] shown;
    logic        dn;
    td     = (u == 0) ? 4 : 2;
    mask   = (u == 0) ? 28'h0 : 28'hFFF_FFFF;
    frames = names[m_day[u]].len() + 5;
    shown  = m_act[u] ? frame_seg(m_day[u], (m_cnt[u] / td) % frames) : 28'h0;
    dn     = 1'b0;
    if (start && day != 3'd7) begin
      m_act[u] = 1'b1;
      m_day[u] = int'(day);
      m_cnt[u] = 0;
    end else if (m_act[u]) begin
      m_cnt[u] = m_cnt[u] + 1;
      if (m_cnt[u] % (frames * td) == 0) begin
        dn = 1'b1;
        if (!loop) m_act[u] = 1'b0;
      end
    end
    if (u == 0) exp_q0.push_back({shown ^ mask, m_act[u], dn});
    else        exp_q1.push_back({shown ^ mask, m_act[u], dn});
  endtask

  task automatic cmp(input string tag, input logic [29:0] got, input logic [29:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got seg=%h busy=%b done=%b, expected seg=%h busy=%b done=%b",
               tag, $time, got[29:2], got[1], got[0], exp[29:2], exp[1], exp[0]);
    end
  endtask

  // Driver
  task automatic drive(input logic s, input logic [2:0] d, input logic l);
    @(negedge clk);
    start = s;
    day   = d;
    loop  = l;
    model_step(0);
    model_step(1);
  endtask

  task automatic idle(input int n, input logic l);
    for (int i = 0; i < n; i++) drive(1'b0, 3'($urandom_range(0, 7)), l);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    cmp("reset_a", {seg_a, busy_a, done_a}, {28'h000_0000, 2'b00});
    cmp("reset_b", {seg_b, busy_b, done_b}, {28'hFFF_FFFF, 2'b00});
    for (int u = 0; u < 2; u++) begin
      m_act[u] = 1'b0;
      m_day[u] = 0;
      m_cnt[u] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q0.size() > 0) cmp("dut_a", {seg_a, busy_a, done_a}, exp_q0.pop_front());
      if (exp_q1.size() > 0) cmp("dut_b", {seg_b, busy_b, done_b}, exp_q1.pop_front());
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    start = 1'b0;
    day   = 3'd0;
    loop  = 1'b0;
    async_reset();

    // Invalid day while idle
    idle(3, 1'b0);
    drive(1'b1, 3'd7, 1'b0);
    idle(4, 1'b0);

    // SUNDAY single pass
    drive(1'b1, 3'd0, 1'b0);
    idle(50, 1'b0);

    // WEDNESDAY looping, invalid start mid-scroll, then stop looping
    drive(1'b1, 3'd3, 1'b1);
    idle(60, 1'b1);
    drive(1'b1, 3'd7, 1'b1);
    idle(30, 1'b1);
    idle(70, 1'b0);

    // SATURDAY restarted as MONDAY at pos 5 of the slow scroller
    drive(1'b1, 3'd6, 1'b0);
    idle(19, 1'b0);
    drive(1'b1, 3'd1, 1'b0);
    idle(60, 1'b0);

    // Start landing exactly on each scroller's final tick
    drive(1'b1, 3'd0, 1'b0);
    idle(21, 1'b0);
    drive(1'b1, 3'd1, 1'b0);
    idle(43, 1'b0);
    drive(1'b1, 3'd2, 1'b0);
    idle(60, 1'b0);

    // Asynchronous reset mid-scroll
    drive(1'b1, 3'd4, 1'b1);
    idle(15, 1'b1);
    async_reset();
    idle(3, 1'b0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 29) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    idle(10, 1'b0);

    @(posedge clk);
    #2;
    n_vec++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
